// File: rtl/program_mode_ctrl.sv
// program_mode_ctrl: timed multi-field program-mode controller.
// A single 100 Hz clock is divided internally into 1 s ticks. A trigger rise
// opens an edit session over NUM_FIELDS fields. Each button rise saves one field.
// Every field has its own TIMEOUT_S window. An error_detection level aborts the
// session into a timed ERROR indication that lasts ERR_HOLD_S seconds.
//
// Ports
//   clk_100Hz           in   system clock, rising edge
//   rst_n               in   asynchronous active-low reset
//   trigger             in   rising edge requests entry to program mode
//   error_detection     in   level; high while editing aborts the session
//   button_signal       in   rising edge saves the current field
//   seconds_left        out  seconds remaining in the current window
//   field_sel           out  index of the field being edited
//   active_program_mode out  high while editing
//   saved               out  1-cycle pulse per saved field
//   all_saved           out  1-cycle pulse when the last field is saved
//   timed_out           out  1-cycle pulse on window expiry
//   error_flag          out  high while in ERROR
module program_mode_ctrl #(
  parameter int unsigned NUM_FIELDS    = 2,
  parameter int unsigned TIMEOUT_S     = 5,
  parameter int unsigned ERR_HOLD_S    = 2,
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned SEC_W         = 3,
  parameter int unsigned FIELD_W       = 1
) (
  input  logic               clk_100Hz,
  input  logic               rst_n,
  input  logic               trigger,
  input  logic               error_detection,
  input  logic               button_signal,
  output logic [SEC_W-1:0]   seconds_left,
  output logic [FIELD_W-1:0] field_sel,
  output logic               active_program_mode,
  output logic               saved,
  output logic               all_saved,
  output logic               timed_out,
  output logic               error_flag
);

  localparam int unsigned PRESC_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [PRESC_W-1:0] PRESC_MAX   = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0]   SEC_TIMEOUT = SEC_W'(TIMEOUT_S);
  localparam logic [SEC_W-1:0]   SEC_ERR     = SEC_W'(ERR_HOLD_S);
  localparam logic [SEC_W-1:0]   SEC_ONE     = SEC_W'(1);
  localparam logic [FIELD_W-1:0] FIELD_LAST  = FIELD_W'(NUM_FIELDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EDIT  = 2'd1,
    S_ERROR = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [FIELD_W-1:0] field_q, field_d;
  logic               active_q, active_d;
  logic               saved_q, saved_d;
  logic               all_saved_q, all_saved_d;
  logic               timed_out_q, timed_out_d;
  logic               err_q, err_d;
  logic               trig_hist_q, btn_hist_q;

  logic               trig_rise, btn_rise, sec_tick;
  logic [PRESC_W-1:0] presc_next;

  assign trig_rise  = trigger & ~trig_hist_q;
  assign btn_rise   = button_signal & ~btn_hist_q;
  assign sec_tick   = (presc_q == PRESC_MAX);
  assign presc_next = sec_tick ? '0 : presc_q + PRESC_W'(1);

  // Next-state and output decode; prescaler stays cleared unless a window is running.
  always_comb begin
    state_d     = state_q;
    presc_d     = '0;
    sec_d       = sec_q;
    field_d     = field_q;
    active_d    = active_q;
    err_d       = err_q;
    saved_d     = 1'b0;
    all_saved_d = 1'b0;
    timed_out_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trig_rise) begin
          state_d  = S_EDIT;
          sec_d    = SEC_TIMEOUT;
          field_d  = '0;
          active_d = 1'b1;
        end
      end

      S_EDIT: begin
        presc_d = presc_next;
        if (error_detection) begin
          state_d  = S_ERROR;
          presc_d  = '0;
          sec_d    = SEC_ERR;
          active_d = 1'b0;
          err_d    = 1'b1;
        end else if (btn_rise && (field_q != FIELD_LAST)) begin
          saved_d = 1'b1;
          field_d = field_q + FIELD_W'(1);
          sec_d   = SEC_TIMEOUT;
          presc_d = '0;
        end else if (btn_rise) begin
          saved_d     = 1'b1;
          all_saved_d = 1'b1;
          state_d     = S_IDLE;
          presc_d     = '0;
          sec_d       = '0;
          field_d     = '0;
          active_d    = 1'b0;
        end else if (sec_tick && (sec_q == SEC_ONE)) begin
          timed_out_d = 1'b1;
          state_d     = S_IDLE;
          presc_d     = '0;
          sec_d       = '0;
          field_d     = '0;
          active_d    = 1'b0;
        end else if (sec_tick) begin
          sec_d = sec_q - SEC_ONE;
        end
      end

      S_ERROR: begin
        presc_d = presc_next;
        if (sec_tick && (sec_q == SEC_ONE)) begin
          state_d  = S_IDLE;
          presc_d  = '0;
          sec_d    = '0;
          field_d  = '0;
          active_d = 1'b0;
          err_d    = 1'b0;
        end else if (sec_tick) begin
          sec_d = sec_q - SEC_ONE;
        end
      end

      default: begin
        state_d  = S_IDLE;
        sec_d    = '0;
        field_d  = '0;
        active_d = 1'b0;
        err_d    = 1'b0;
      end
    endcase
  end

  // State, outputs and edge history. History resets high so an input already
  // high at reset release is not seen as a rising edge.
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      sec_q       <= '0;
      field_q     <= '0;
      active_q    <= 1'b0;
      saved_q     <= 1'b0;
      all_saved_q <= 1'b0;
      timed_out_q <= 1'b0;
      err_q       <= 1'b0;
      trig_hist_q <= 1'b1;
      btn_hist_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      field_q     <= field_d;
      active_q    <= active_d;
      saved_q     <= saved_d;
      all_saved_q <= all_saved_d;
      timed_out_q <= timed_out_d;
      err_q       <= err_d;
      trig_hist_q <= trigger;
      btn_hist_q  <= button_signal;
    end
  end

  assign seconds_left        = sec_q;
  assign field_sel           = field_q;
  assign active_program_mode = active_q;
  assign saved               = saved_q;
  assign all_saved           = all_saved_q;
  assign timed_out           = timed_out_q;
  assign error_flag          = err_q;

endmodule

// File: tb/tb_program_mode_ctrl.sv
// tb_program_mode_ctrl: directed vectors for program_mode_ctrl with a fast
// prescaler (4 ticks/s, 5 s field window, 2 s error hold, 2 fields).
module tb_program_mode_ctrl;

  logic       clk_100Hz = 1'b0;
  logic       rst_n;
  logic       trigger;
  logic       error_detection;
  logic       button_signal;
  logic [2:0] seconds_left;
  logic [0:0] field_sel;
  logic       active_program_mode;
  logic       saved;
  logic       all_saved;
  logic       timed_out;
  logic       error_flag;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  program_mode_ctrl #(
    .NUM_FIELDS   (2),
    .TIMEOUT_S    (5),
    .ERR_HOLD_S   (2),
    .TICKS_PER_SEC(4),
    .SEC_W        (3),
    .FIELD_W      (1)
  ) dut (
    .clk_100Hz          (clk_100Hz),
    .rst_n              (rst_n),
    .trigger            (trigger),
    .error_detection    (error_detection),
    .button_signal      (button_signal),
    .seconds_left       (seconds_left),
    .field_sel          (field_sel),
    .active_program_mode(active_program_mode),
    .saved              (saved),
    .all_saved          (all_saved),
    .timed_out          (timed_out),
    .error_flag         (error_flag)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic step();
    @(posedge clk_100Hz);
    #1;
  endtask

  // Produce a trigger rise; on return the session has just been entered (cycle 0).
  task automatic enter_edit();
    trigger = 1'b0;
    step();
    trigger = 1'b1;
    step();
  endtask

  task automatic check_outputs(input string tag, input int sec, input int fld, input bit act,
                               input bit sv, input bit alls, input bit tmo, input bit err);
    check_eq({tag, ".sec"},   32'(seconds_left),        32'(sec));
    check_eq({tag, ".field"}, 32'(field_sel),           32'(fld));
    check_eq({tag, ".act"},   32'(active_program_mode), 32'(act));
    check_eq({tag, ".saved"}, 32'(saved),               32'(sv));
    check_eq({tag, ".alls"},  32'(all_saved),           32'(alls));
    check_eq({tag, ".tmo"},   32'(timed_out),           32'(tmo));
    check_eq({tag, ".err"},   32'(error_flag),          32'(err));
  endtask

  initial begin
    rst_n           = 1'b0;
    trigger         = 1'b1;
    error_detection = 1'b0;
    button_signal   = 1'b0;
    #12;
    check_outputs("reset", 0, 0, 0, 0, 0, 0, 0);

    // Trigger held high through reset release must not start a session.
    @(posedge clk_100Hz);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_outputs("trig_held", 0, 0, 0, 0, 0, 0, 0);
    enter_edit();
    check_outputs("enter", 5, 0, 1, 0, 0, 0, 0);

    // No button: one second per 4 cycles, timeout on cycle 20.
    for (int i = 1; i <= 21; i++) begin
      step();
      if (i < 20)
        check_outputs($sformatf("tmo_c%0d", i), 5 - i / 4, 0, 1, 0, 0, 0, 0);
      else if (i == 20)
        check_outputs("tmo_c20", 0, 0, 0, 0, 0, 1, 0);
      else
        check_outputs("tmo_c21", 0, 0, 0, 0, 0, 0, 0);
    end

    // Two saves: field 0 on cycle 6, field 1 on cycle 10.
    enter_edit();
    for (int i = 1; i <= 5; i++) step();
    check_outputs("save_c5", 4, 0, 1, 0, 0, 0, 0);
    button_signal = 1'b1;
    step();
    check_outputs("save_c6", 5, 1, 1, 1, 0, 0, 0);
    button_signal = 1'b0;
    step();
    check_outputs("save_c7", 5, 1, 1, 0, 0, 0, 0);
    step();
    step();
    check_outputs("save_c9", 5, 1, 1, 0, 0, 0, 0);
    button_signal = 1'b1;
    step();
    check_outputs("save_c10", 0, 0, 0, 1, 1, 0, 0);
    button_signal = 1'b0;
    for (int i = 11; i <= 32; i++) begin
      step();
      check_outputs($sformatf("save_c%0d", i), 0, 0, 0, 0, 0, 0, 0);
    end

    // Button rise together with error: error wins, no save, 8-cycle error hold.
    enter_edit();
    step();
    step();
    button_signal   = 1'b1;
    error_detection = 1'b1;
    step();
    check_outputs("err_entry", 2, 0, 0, 0, 0, 0, 1);
    for (int j = 1; j <= 9; j++) begin
      step();
      if (j < 4)
        check_outputs($sformatf("err_j%0d", j), 2, 0, 0, 0, 0, 0, 1);
      else if (j < 8)
        check_outputs($sformatf("err_j%0d", j), 1, 0, 0, 0, 0, 0, 1);
      else
        check_outputs($sformatf("err_j%0d", j), 0, 0, 0, 0, 0, 0, 0);
    end
    error_detection = 1'b0;
    button_signal   = 1'b0;
    step();

    // Trigger re-raised mid-session does not restart the window.
    enter_edit();
    step();
    step();
    trigger = 1'b0;
    step();
    trigger = 1'b1;
    step();
    check_outputs("retrig_c4", 4, 0, 1, 0, 0, 0, 0);
    button_signal = 1'b1;
    step();
    check_outputs("retrig_c5", 5, 1, 1, 1, 0, 0, 0);
    button_signal = 1'b0;
    step();
    check_outputs("retrig_c6", 5, 1, 1, 0, 0, 0, 0);

    // Asynchronous reset mid-session.
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check_outputs("rst_hold", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    check_outputs("rst_rel", 0, 0, 0, 0, 0, 0, 0);

    // Button rise in IDLE is ignored.
    button_signal = 1'b1;
    step();
    check_outputs("idle_btn", 0, 0, 0, 0, 0, 0, 0);
    step();
    check_outputs("idle_btn2", 0, 0, 0, 0, 0, 0, 0);
    button_signal = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
